// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types.
// Word/line/beat typedefs and the line-adapter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [2:0]   lc3b_beat;

  typedef enum logic [1:0] {
    IDLE,
    READ_BURST,
    WRITE_BURST,
    DONE
  } adapter_state_t;

endpackage

// File: rtl/line_word_buffer.sv
// 128-bit line register, loadable as a whole line or one 16-bit word.
// Ports: clk, reset (async, active-high), line_load/line_in,
//        word_load/index/word_in, data (registered line).
module line_word_buffer
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     line_load,
  input  lc3b_line line_in,
  input  logic     word_load,
  input  lc3b_beat index,
  input  lc3b_word word_in,
  output lc3b_line data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (line_load) begin
      data <= line_in;
    end else if (word_load) begin
      data[16*index +: 16] <= word_in;
    end
  end

endmodule

// File: rtl/pmem_line_adapter.sv
// Serves whole-line cache fills/write-backs as 8-beat word bursts.
// Ports: clk, reset (async, active-high);
//   cache side: pmem_read, pmem_write, pmem_address, pmem_wdata,
//               pmem_rdata, pmem_resp;
//   memory side: mem_read, mem_write, mem_address, mem_wdata,
//                mem_rdata, mem_resp.
module pmem_line_adapter
  import lc3b_types::*;
#(
  parameter int BEATS      = 8,
  parameter int WORD_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [15:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [15:0]           mem_address,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam lc3b_beat LAST_BEAT = lc3b_beat'(BEATS - 1);

  adapter_state_t state_q, state_d;
  lc3b_beat       beat_q;
  logic [15:0]    base_q;
  logic           accept;
  logic           accept_write;
  logic           beat_adv;
  logic [LINE_WIDTH-1:0] wbuf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    pmem_resp    = 1'b0;
    accept       = 1'b0;
    accept_write = 1'b0;
    beat_adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Read has priority; a concurrent write is simply not taken.
        if (pmem_read) begin
          accept  = 1'b1;
          state_d = READ_BURST;
        end else if (pmem_write) begin
          accept       = 1'b1;
          accept_write = 1'b1;
          state_d      = WRITE_BURST;
        end
      end
      READ_BURST: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          if (beat_q == LAST_BEAT) state_d = DONE;
          else                     beat_adv = 1'b1;
        end
      end
      WRITE_BURST: begin
        mem_write = 1'b1;
        if (mem_resp) begin
          if (beat_q == LAST_BEAT) state_d = DONE;
          else                     beat_adv = 1'b1;
        end
      end
      DONE: begin
        pmem_resp = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      beat_q <= '0;
    end else if (accept) begin
      base_q <= pmem_address & 16'hFFF0;
      beat_q <= '0;
    end else if (beat_adv) begin
      beat_q <= beat_q + 3'd1;
    end
  end

  assign mem_address = base_q + 16'({beat_q, 1'b0});
  assign mem_wdata   = wbuf_q[WORD_WIDTH*beat_q +: WORD_WIDTH];

  line_word_buffer u_rbuf (
    .clk       (clk),
    .reset     (reset),
    .line_load (1'b0),
    .line_in   ('0),
    .word_load (mem_read & mem_resp),
    .index     (beat_q),
    .word_in   (mem_rdata),
    .data      (pmem_rdata)
  );

  line_word_buffer u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .line_load (accept_write),
    .line_in   (pmem_wdata),
    .word_load (1'b0),
    .index     (beat_q),
    .word_in   ('0),
    .data      (wbuf_q)
  );

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Directed self-checking bench for pmem_line_adapter.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_pmem_line_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;
  logic [127:0] last_line;

  always #5 clk = ~clk;

  pmem_line_adapter dut (
    .clk          (clk),
    .reset        (reset),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pmem_read = 0; pmem_write = 0;
    pmem_address = '0; pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 0;
    #3;
    checks++;
    if ({mem_read, mem_write, pmem_resp} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000",
               {mem_read, mem_write, pmem_resp});
    end
    checks++;
    if (pmem_rdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0", pmem_rdata);
    end
    checks++;
    if (mem_address !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_addr got %h/%h want 0/0",
               mem_address, mem_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // Beats acked back-to-back; resp expected 8 edges after accept.
  task automatic test_fill;
    pmem_read = 1; pmem_address = 16'h1236;
    tick();
    pmem_read = 0; pmem_address = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 16'h1230 + 16'(2*k)
          || pmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL fill_beat%0d got rd=%b addr=%h resp=%b want 1 %h 0",
                 k, mem_read, mem_address, pmem_resp,
                 16'h1230 + 16'(2*k));
      end
      mem_resp = 1; mem_rdata = 16'hA000 + 16'(k);
      tick();
    end
    mem_resp = 0;
    checks++;
    if (pmem_resp !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL fill_resp got resp=%b rd=%b want 1 0",
               pmem_resp, mem_read);
    end
    checks++;
    if (pmem_rdata !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
      errors++;
      $display("FAIL fill_rdata got %h", pmem_rdata);
    end
    tick();
    checks++;
    if (pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL fill_resp_pulse got %b want 0", pmem_resp);
    end
    last_line = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
  endtask

  task automatic test_write_stall;
    pmem_write = 1; pmem_address = 16'h4A50;
    pmem_wdata = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    tick();
    pmem_write = 0; pmem_address = 16'h0000;
    pmem_wdata = {8{16'hDEAD}};
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < 3; s++) begin
        mem_resp = (s == 2);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0
            || mem_address !== 16'h4A50 + 16'(2*k)
            || mem_wdata !== 16'(k) || pmem_resp !== 1'b0) begin
          errors++;
          $display("FAIL wb_beat%0d_s%0d got wr=%b rd=%b addr=%h data=%h want 1 0 %h %h",
                   k, s, mem_write, mem_read, mem_address, mem_wdata,
                   16'h4A50 + 16'(2*k), 16'(k));
        end
        tick();
      end
    end
    mem_resp = 0;
    checks++;
    if (pmem_resp !== 1'b1 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL wb_resp got resp=%b wr=%b want 1 0",
               pmem_resp, mem_write);
    end
    checks++;
    if (pmem_rdata !== last_line) begin
      errors++;
      $display("FAIL wb_rdata_kept got %h want %h", pmem_rdata, last_line);
    end
    tick();
    checks++;
    if (pmem_resp !== 1'b0) begin
      errors++;
      $display("FAIL wb_resp_pulse got %b want 0", pmem_resp);
    end
  endtask

  task automatic test_both_requests;
    pmem_read = 1; pmem_write = 1; pmem_address = 16'h0800;
    pmem_wdata = {8{16'h5555}};
    tick();
    pmem_read = 0; pmem_write = 0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0
          || mem_address !== 16'h0800 + 16'(2*k)) begin
        errors++;
        $display("FAIL both_beat%0d got rd=%b wr=%b addr=%h want 1 0 %h",
                 k, mem_read, mem_write, mem_address,
                 16'h0800 + 16'(2*k));
      end
      mem_resp = 1; mem_rdata = 16'hB000 + 16'(k);
      tick();
    end
    mem_resp = 0;
    checks++;
    if (pmem_resp !== 1'b1
        || pmem_rdata !== 128'hB007_B006_B005_B004_B003_B002_B001_B000) begin
      errors++;
      $display("FAIL both_done got resp=%b rdata=%h", pmem_resp, pmem_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst;
    pmem_read = 1; pmem_address = 16'h2000;
    tick();
    pmem_read = 0;
    for (int k = 0; k < 4; k++) begin
      mem_resp = 1; mem_rdata = 16'hC000 + 16'(k);
      tick();
    end
    mem_resp = 0;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 16'h2008) begin
      errors++;
      $display("FAIL rst_pre got rd=%b addr=%h want 1 2008",
               mem_read, mem_address);
    end
    reset = 1;
    #2;
    checks++;
    if (mem_read !== 1'b0 || pmem_resp !== 1'b0
        || pmem_rdata !== 128'h0 || mem_address !== 16'h0) begin
      errors++;
      $display("FAIL rst_async got rd=%b resp=%b rdata=%h addr=%h want 0 0 0 0",
               mem_read, pmem_resp, pmem_rdata, mem_address);
    end
    @(negedge clk);
    reset = 0;
    tick();
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got rd=%b want 0", mem_read);
    end
    pmem_read = 1; pmem_address = 16'h2010;
    tick();
    pmem_read = 0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_read !== 1'b1 || mem_address !== 16'h2010 + 16'(2*k)) begin
        errors++;
        $display("FAIL rst_refill%0d got rd=%b addr=%h want 1 %h",
                 k, mem_read, mem_address, 16'h2010 + 16'(2*k));
      end
      mem_resp = 1; mem_rdata = 16'hD000 + 16'(k);
      tick();
    end
    mem_resp = 0;
    checks++;
    if (pmem_resp !== 1'b1
        || pmem_rdata !== 128'hD007_D006_D005_D004_D003_D002_D001_D000) begin
      errors++;
      $display("FAIL rst_refill_done got resp=%b rdata=%h",
               pmem_resp, pmem_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [127:0] line1, line2;
    line1 = 128'hE007_E006_E005_E004_E003_E002_E001_E000;
    line2 = 128'hF007_F006_F005_F004_F003_F002_F001_F000;
    pmem_read = 1; pmem_address = 16'h3000;
    tick();
    for (int k = 0; k < 8; k++) begin
      mem_resp = 1; mem_rdata = 16'hE000 + 16'(k);
      tick();
    end
    mem_resp = 0;
    pmem_address = 16'h3100;
    checks++;
    if (pmem_resp !== 1'b1 || pmem_rdata !== line1) begin
      errors++;
      $display("FAIL b2b_first got resp=%b rdata=%h", pmem_resp, pmem_rdata);
    end
    tick();
    checks++;
    if (pmem_resp !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got resp=%b rd=%b want 0 0",
               pmem_resp, mem_read);
    end
    tick();
    pmem_read = 0;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 16'h3100
        || pmem_rdata !== line1) begin
      errors++;
      $display("FAIL b2b_second_start got rd=%b addr=%h rdata=%h",
               mem_read, mem_address, pmem_rdata);
    end
    mem_resp = 1; mem_rdata = 16'hF000;
    tick();
    checks++;
    if (pmem_rdata !== {line1[127:16], 16'hF000}) begin
      errors++;
      $display("FAIL b2b_partial got %h want %h",
               pmem_rdata, {line1[127:16], 16'hF000});
    end
    for (int k = 1; k < 8; k++) begin
      mem_resp = 1; mem_rdata = 16'hF000 + 16'(k);
      tick();
    end
    mem_resp = 0;
    checks++;
    if (pmem_resp !== 1'b1 || pmem_rdata !== line2) begin
      errors++;
      $display("FAIL b2b_second got resp=%b rdata=%h want 1 %h",
               pmem_resp, pmem_rdata, line2);
    end
    tick();
    last_line = line2;
  endtask

  task automatic test_spurious_resp;
    mem_resp = 1; mem_rdata = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || pmem_resp !== 1'b0
          || pmem_rdata !== last_line) begin
        errors++;
        $display("FAIL spurious%0d got rd=%b wr=%b resp=%b rdata=%h",
                 i, mem_read, mem_write, pmem_resp, pmem_rdata);
      end
    end
    mem_resp = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_stall();
    test_both_requests();
    test_reset_mid_burst();
    test_back_to_back();
    test_spurious_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
